// File: rtl/data_mem_arbiter.sv
// Two-requester data-memory arbiter: the core has priority and the DMA gets a guaranteed slot
// after STARVE_LIMIT consecutive lost cycles. Responses are registered one cycle after grant.
module data_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_core_valid,
    input  logic        i_core_we,
    input  logic [31:0] i_core_addr,
    input  logic [31:0] i_core_wd,
    input  logic [1:0]  i_core_mask_type,
    input  logic        i_core_ext_type,
    output logic        o_core_ready,
    output logic        o_core_stall,
    output logic        o_core_rvalid,
    output logic [31:0] o_core_rd,

    input  logic        i_dma_valid,
    input  logic        i_dma_we,
    input  logic [31:0] i_dma_addr,
    input  logic [31:0] i_dma_wd,
    input  logic [1:0]  i_dma_mask_type,
    input  logic        i_dma_ext_type,
    output logic        o_dma_ready,
    output logic        o_dma_rvalid,
    output logic [31:0] o_dma_rd,

    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wd,
    output logic [1:0]  o_mem_mask_type,
    output logic        o_mem_ext_type,
    input  logic [31:0] i_mem_rd
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RESP_CORE = 2'd1;
    localparam logic [1:0] RESP_DMA  = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] core_rd_q, core_rd_d;
    logic [31:0] dma_rd_q, dma_rd_d;

    logic grant_core;
    logic grant_dma;
    logic dma_forced;

    // Reset suppresses every grant so no write can slip through during the reset cycle.
    always_comb begin
        dma_forced = i_dma_valid && (starve_cnt_q == LIMIT);
        grant_core = 1'b0;
        grant_dma  = 1'b0;
        if (!i_rst) begin
            if (i_core_valid && !dma_forced) begin
                grant_core = 1'b1;
            end else if (i_dma_valid) begin
                grant_dma = 1'b1;
            end
        end
    end

    always_comb begin
        o_mem_we        = 1'b0;
        o_mem_addr      = 32'h0;
        o_mem_wd        = 32'h0;
        o_mem_mask_type = 2'b00;
        o_mem_ext_type  = 1'b0;
        if (grant_core) begin
            o_mem_we        = i_core_we;
            o_mem_addr      = i_core_addr;
            o_mem_wd        = i_core_wd;
            o_mem_mask_type = i_core_mask_type;
            o_mem_ext_type  = i_core_ext_type;
        end else if (grant_dma) begin
            o_mem_we        = i_dma_we;
            o_mem_addr      = i_dma_addr;
            o_mem_wd        = i_dma_wd;
            o_mem_mask_type = i_dma_mask_type;
            o_mem_ext_type  = i_dma_ext_type;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (grant_core) begin
            state_d = RESP_CORE;
        end else if (grant_dma) begin
            state_d = RESP_DMA;
        end

        // Counter only tracks an uninterrupted losing streak; any gap in DMA valid restarts it.
        starve_cnt_d = starve_cnt_q;
        if (!i_dma_valid || grant_dma) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        core_rd_d = core_rd_q;
        if (grant_core) begin
            core_rd_d = i_core_we ? 32'h0 : i_mem_rd;
        end

        dma_rd_d = dma_rd_q;
        if (grant_dma) begin
            dma_rd_d = i_dma_we ? 32'h0 : i_mem_rd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            core_rd_q    <= 32'h0;
            dma_rd_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            core_rd_q    <= core_rd_d;
            dma_rd_q     <= dma_rd_d;
        end
    end

    assign o_core_ready = grant_core;
    assign o_dma_ready  = grant_dma;
    assign o_core_stall = i_core_valid & ~grant_core;

    // A response pending from the cycle before reset is dropped rather than delivered.
    assign o_core_rvalid = (state_q == RESP_CORE) && !i_rst;
    assign o_dma_rvalid  = (state_q == RESP_DMA) && !i_rst;
    assign o_core_rd     = core_rd_q;
    assign o_dma_rd      = dma_rd_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (losing-streak count, pending response owner, word memory).
module tb_data_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid, core_we, core_ext;
    logic [31:0] core_addr, core_wd;
    logic [1:0]  core_mask;
    logic        dma_valid, dma_we, dma_ext;
    logic [31:0] dma_addr, dma_wd;
    logic [1:0]  dma_mask;
    logic        core_ready, core_stall, core_rvalid;
    logic [31:0] core_rd;
    logic        dma_ready, dma_rvalid;
    logic [31:0] dma_rd;
    logic        mem_we, mem_ext;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [1:0]  mem_mask;

    always #5 clk = ~clk;

    data_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_core_valid(core_valid), .i_core_we(core_we), .i_core_addr(core_addr),
        .i_core_wd(core_wd), .i_core_mask_type(core_mask), .i_core_ext_type(core_ext),
        .o_core_ready(core_ready), .o_core_stall(core_stall), .o_core_rvalid(core_rvalid),
        .o_core_rd(core_rd),
        .i_dma_valid(dma_valid), .i_dma_we(dma_we), .i_dma_addr(dma_addr),
        .i_dma_wd(dma_wd), .i_dma_mask_type(dma_mask), .i_dma_ext_type(dma_ext),
        .o_dma_ready(dma_ready), .o_dma_rvalid(dma_rvalid), .o_dma_rd(dma_rd),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wd(mem_wd),
        .o_mem_mask_type(mem_mask), .o_mem_ext_type(mem_ext), .i_mem_rd(mem_rd)
    );

    // Reference memory: word-addressed, 64 words.
    logic [31:0] ref_mem [64];
    assign mem_rd = ref_mem[mem_addr[7:2]];

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int unsigned lost_streak;
    int          owner;          // 0 none, 1 core, 2 dma
    logic [31:0] exp_core_rd, exp_dma_rd;
    // Model outputs for the current cycle
    logic        g_core, g_dma;
    logic [8:0]  exp_ctrl;
    logic [31:0] exp_addr, exp_wd;

    task automatic model_eval();
        logic we, ext;
        logic [1:0] mask;
        g_core = 1'b0;
        g_dma  = 1'b0;
        if (!rst) begin
            if (core_valid && !(dma_valid && lost_streak >= LIMIT)) g_core = 1'b1;
            else if (dma_valid) g_dma = 1'b1;
        end
        we = 1'b0; mask = 2'b00; ext = 1'b0; exp_addr = 32'h0; exp_wd = 32'h0;
        if (g_core) begin
            we = core_we; mask = core_mask; ext = core_ext; exp_addr = core_addr; exp_wd = core_wd;
        end else if (g_dma) begin
            we = dma_we; mask = dma_mask; ext = dma_ext; exp_addr = dma_addr; exp_wd = dma_wd;
        end
        exp_ctrl = {g_core, g_dma, core_valid & ~g_core, we,
                    !rst && owner == 1, !rst && owner == 2, mask, ext};
    endtask

    task automatic model_commit();
        if (rst) begin
            lost_streak = 0; owner = 0; exp_core_rd = 32'h0; exp_dma_rd = 32'h0;
        end else begin
            owner = g_core ? 1 : (g_dma ? 2 : 0);
            if (g_core) begin
                exp_core_rd = core_we ? 32'h0 : ref_mem[core_addr[7:2]];
                if (core_we) ref_mem[core_addr[7:2]] = core_wd;
            end
            if (g_dma) begin
                exp_dma_rd = dma_we ? 32'h0 : ref_mem[dma_addr[7:2]];
                if (dma_we) ref_mem[dma_addr[7:2]] = dma_wd;
            end
            if (!dma_valid || g_dma) lost_streak = 0;
            else if (lost_streak < LIMIT) lost_streak++;
        end
    endtask

    // Apply one cycle of stimulus and evaluate the model; callers compare, then commit.
    task automatic step(input logic r, input logic cv, input logic cwe, input logic [31:0] ca,
                        input logic [31:0] cwd, input logic dv, input logic dwe,
                        input logic [31:0] da, input logic [31:0] dwd);
        @(negedge clk);
        rst = r;
        core_valid = cv; core_we = cwe; core_addr = ca; core_wd = cwd;
        core_mask = ca[5:4] ^ cwd[1:0]; core_ext = cwd[2];
        dma_valid = dv; dma_we = dwe; dma_addr = da; dma_wd = dwd;
        dma_mask = da[5:4] ^ dwd[1:0]; dma_ext = dwd[2];
        #1;
        model_eval();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_commit();
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [5:0] w;
        w = 6'($urandom);
        return {24'h0, w, 2'b00};
    endfunction

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 32'h4, 32'h5, 1'b1, 1'b1, 32'h8, 32'h9);
        n_checks++;
        if ({core_ready, dma_ready, mem_we, core_stall} !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_grants got %b want 0001", {core_ready, dma_ready, mem_we, core_stall});
        end
        model_commit();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if ({core_rvalid, dma_rvalid, core_rd, dma_rd, core_stall} !== 67'h0) begin
            n_errors++;
            $display("FAIL reset_state rv=%b%b core_rd=%h dma_rd=%h stall=%b want all 0",
                     core_rvalid, dma_rvalid, core_rd, dma_rd, core_stall);
        end
        model_commit();
        idle();
    endtask

    task automatic test_core_read();
        idle();
        ref_mem[4] = 32'hDEADBEEF;
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if ({core_ready, core_stall, mem_we, mem_addr} !== {3'b100, 32'h10}) begin
            n_errors++;
            $display("FAIL core_read_grant got rdy=%b stall=%b we=%b addr=%h want 1 0 0 10",
                     core_ready, core_stall, mem_we, mem_addr);
        end
        model_commit();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if ({core_rvalid, dma_rvalid, core_rd} !== {2'b10, 32'hDEADBEEF}) begin
            n_errors++;
            $display("FAIL core_read_resp got rv=%b drv=%b rd=%h want 1 0 deadbeef",
                     core_rvalid, dma_rvalid, core_rd);
        end
        model_commit();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if ({core_rvalid, core_rd} !== {1'b0, 32'hDEADBEEF}) begin
            n_errors++;
            $display("FAIL core_rd_hold got rv=%b rd=%h want 0 deadbeef", core_rvalid, core_rd);
        end
        model_commit();
    endtask

    task automatic test_starve();
        idle();
        for (int c = 0; c < 10; c++) begin
            logic want_dma;
            want_dma = (c == 4) || (c == 9);
            step(1'b0, 1'b1, 1'b0, rnd_addr(), 32'h0, 1'b1, 1'b0, rnd_addr(), 32'h0);
            n_checks++;
            if ({dma_ready, core_ready, core_stall} !== {want_dma, !want_dma, want_dma}) begin
                n_errors++;
                $display("FAIL starve_c%0d got dma=%b core=%b stall=%b want %b %b %b", c,
                         dma_ready, core_ready, core_stall, want_dma, !want_dma, want_dma);
            end
            model_commit();
        end
        idle();
    endtask

    task automatic test_dma_write();
        idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        n_checks++;
        if ({dma_ready, mem_we, mem_addr, mem_wd} !== {2'b11, 32'h20, 32'h12345678}) begin
            n_errors++;
            $display("FAIL dma_write_grant got rdy=%b we=%b addr=%h wd=%h want 1 1 20 12345678",
                     dma_ready, mem_we, mem_addr, mem_wd);
        end
        model_commit();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if ({dma_rvalid, core_rvalid, dma_rd} !== {2'b10, 32'h0}) begin
            n_errors++;
            $display("FAIL dma_write_resp got rv=%b crv=%b rd=%h want 1 0 0",
                     dma_rvalid, core_rvalid, dma_rd);
        end
        model_commit();
        // Read the word back through the core to confirm the write landed at the grant edge.
        step(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_commit();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (core_rd !== 32'h12345678) begin
            n_errors++;
            $display("FAIL dma_write_readback got %h want 12345678", core_rd);
        end
        model_commit();
    endtask

    task automatic test_reset_mid();
        idle();
        // Build a partial losing streak, then reset right after a core read grant.
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
            model_commit();
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (core_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_rvalid got %b want 0", core_rvalid);
        end
        model_commit();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if ({core_rvalid, core_rd} !== 33'h0) begin
            n_errors++;
            $display("FAIL reset_mid_after got rv=%b rd=%h want 0 0", core_rvalid, core_rd);
        end
        model_commit();
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
            n_checks++;
            if (dma_ready !== (c == 4)) begin
                n_errors++;
                $display("FAIL reset_mid_streak_c%0d got %b want %b", c, dma_ready, c == 4);
            end
            model_commit();
        end
        idle();
    endtask

    task automatic test_dma_restart();
        idle();
        for (int c = 0; c < 9; c++) begin
            logic dv, want;
            dv = (c != 3);
            want = (c == 8);
            step(1'b0, 1'b1, 1'b0, rnd_addr(), 32'h0, dv, 1'b0, 32'h30, 32'h0);
            n_checks++;
            if ({dma_ready, core_ready} !== {want, !want}) begin
                n_errors++;
                $display("FAIL dma_restart_c%0d got dma=%b core=%b want %b %b", c,
                         dma_ready, core_ready, want, !want);
            end
            model_commit();
        end
        idle();
    endtask

    task automatic test_random();
        logic        hold, dv, dwe;
        logic [31:0] da, dwd;
        hold = 1'b0; dv = 1'b0; dwe = 1'b0; da = 32'h0; dwd = 32'h0;
        for (int i = 0; i < 500; i++) begin
            logic r, cv;
            r  = ($urandom_range(0, 49) == 0);
            cv = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                dv  = 1'($urandom_range(0, 1));
                dwe = 1'($urandom_range(0, 1));
                da  = rnd_addr();
                dwd = $urandom;
            end
            step(r, cv, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, dv, dwe, da, dwd);
            n_checks++;
            if ({core_ready, dma_ready, core_stall, mem_we, core_rvalid, dma_rvalid, mem_mask,
                 mem_ext} !== exp_ctrl) begin
                n_errors++;
                $display("FAIL rand_ctrl_%0d got %b want %b", i,
                         {core_ready, dma_ready, core_stall, mem_we, core_rvalid, dma_rvalid,
                          mem_mask, mem_ext}, exp_ctrl);
            end
            n_checks++;
            if ({mem_addr, mem_wd} !== {exp_addr, exp_wd}) begin
                n_errors++;
                $display("FAIL rand_mem_%0d got %h/%h want %h/%h", i, mem_addr, mem_wd,
                         exp_addr, exp_wd);
            end
            n_checks++;
            if ({core_rd, dma_rd} !== {exp_core_rd, exp_dma_rd}) begin
                n_errors++;
                $display("FAIL rand_rd_%0d got %h/%h want %h/%h", i, core_rd, dma_rd,
                         exp_core_rd, exp_dma_rd);
            end
            hold = dma_valid && !g_dma && !rst;
            model_commit();
        end
    endtask

    initial begin
        rst = 1'b1;
        core_valid = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wd = 32'h0;
        core_mask = 2'b00; core_ext = 1'b0;
        dma_valid = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wd = 32'h0;
        dma_mask = 2'b00; dma_ext = 1'b0;
        lost_streak = 0; owner = 0; exp_core_rd = 32'h0; exp_dma_rd = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;

        test_reset();
        test_core_read();
        test_starve();
        test_dma_write();
        test_reset_mid();
        test_dma_restart();
        test_random();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning max consecutive cycles a pending DMA request may lose arbitration (range 1..15).
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_core_valid  input  1, i_core_we  input  1, i_core_addr  input  32, i_core_wd  input  32, i_core_mask_type  input  2, i_core_ext_type  input  1: core MEM-stage request.
REQ-005 SHALL have ports o_core_ready  output  1 (request granted this cycle), o_core_stall  output  1 (core must hold pipeline), o_core_rvalid  output  1, o_core_rd  output  32: core response.
REQ-006 SHALL have ports i_dma_valid, i_dma_we (input 1 each), i_dma_addr, i_dma_wd (input 32), i_dma_mask_type (input 2), i_dma_ext_type (input 1): DMA request.
REQ-007 SHALL have ports o_dma_ready  output  1, o_dma_rvalid  output  1, o_dma_rd  output  32: DMA handshake/response.
REQ-008 SHALL have ports o_mem_we  output  1, o_mem_addr  output  32, o_mem_wd  output  32, o_mem_mask_type  output  2, o_mem_ext_type  output  1, i_mem_rd  input  32: data memory port (combinational read, write on i_clk edge).

Function
REQ-009 SHALL grant at most one requester per cycle; grant is combinational from current valids and state.
REQ-010 SHALL grant core when i_core_valid=1, unless starve_cnt == STARVE_LIMIT and i_dma_valid=1, in which case DMA is granted.
REQ-011 SHALL grant DMA when i_dma_valid=1 and i_core_valid=0.
REQ-012 SHALL drive o_mem_* from the granted requester's fields; with no grant, o_mem_we=0, o_mem_addr=0, o_mem_wd=0, o_mem_mask_type=0, o_mem_ext_type=0.
REQ-013 SHALL assert o_core_ready / o_dma_ready exactly in the cycle the respective request is granted.
REQ-014 SHALL drive o_core_stall = i_core_valid & ~o_core_ready.
REQ-015 SHALL keep 4-bit starve_cnt: +1 each cycle i_dma_valid=1 and DMA not granted (saturating at STARVE_LIMIT); cleared to 0 on DMA grant or when i_dma_valid=0.
REQ-016 SHALL register response: cycle after a grant, owner's rvalid=1 for exactly one cycle; rd = i_mem_rd captured at grant if read, 32'h0 if write.
REQ-017 SHALL hold o_core_rd / o_dma_rd at their last value when rvalid=0.
REQ-018 SHALL complete writes at the grant edge; back-to-back grants (every cycle) SHALL be supported with no bubble.
REQ-019 SHALL tolerate i_core_valid dropping without grant (pipeline flush): no state change except starve_cnt rules.
REQ-020 DMA requester SHALL hold all i_dma_* stable while i_dma_valid=1 and o_dma_ready=0; arbiter need not check this.
REQ-021 SHALL implement state register {IDLE, RESP_CORE, RESP_DMA}: next = RESP_CORE on core grant, RESP_DMA on DMA grant, else IDLE; rvalid outputs decoded from state.

Reset
REQ-022 SHALL, while i_rst=1 at a clock edge, set state=IDLE, starve_cnt=0, o_core_rd=0, o_dma_rd=0; o_core_rvalid=o_dma_rvalid=0 the following cycle.
REQ-023 SHALL, during the i_rst=1 cycle, suppress all grants: ready outputs 0, o_mem_we=0, o_core_stall = i_core_valid.
REQ-024 SHALL drop any response pending from the cycle before reset (no rvalid after reset).

Verification
REQ-025 Core read only: addr 0x10, mem returns 0xDEADBEEF -> o_core_ready=1 same cycle, next cycle o_core_rvalid=1, o_core_rd=0xDEADBEEF, o_core_stall=0.
REQ-026 Both valid every cycle, STARVE_LIMIT=4 -> core granted cycles 0-3, DMA granted cycle 4 (o_core_stall=1 there), core cycle 5, DMA again cycle 9.
REQ-027 DMA write 0x20 data 0x12345678 with core idle -> o_mem_we=1, o_mem_addr=0x20 same cycle, next cycle o_dma_rvalid=1, o_dma_rd=0.
REQ-028 Reset asserted in cycle after core read grant -> no o_core_rvalid, o_core_rd=0, starve_cnt=0.
REQ-029 DMA valid 3 cycles, drops 1 cycle, re-asserts with core busy -> starve_cnt restarts at 0; DMA granted only after 4 further lost cycles.
